// File: rtl/c2c_sym_packer.sv
`default_nettype none
// ============================================================================
// Module      : c2c_sym_packer
// Description : Pops {ctl,nib} symbols from the C2C FIFO, strips framing and
//               packs data nibbles LSB-first into words on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module c2c_sym_packer #(
    parameter int NIB_PER_WORD = 8,
    parameter int CW           = $clog2(NIB_PER_WORD + 1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    output logic                      RDEN,
    input  logic [4:0]                RDATA,
    input  logic                      EMPTY,
    output logic                      O_VALID,
    input  logic                      O_READY,
    output logic [4*NIB_PER_WORD-1:0] O_DATA,
    output logic [CW-1:0]             O_NCNT,
    output logic                      O_LAST,
    output logic                      O_ERR,
    output logic [7:0]                ERR_CNT
);

    localparam int                 c_CNT_W    = $clog2(NIB_PER_WORD);
    localparam int                 c_DW       = 4 * NIB_PER_WORD;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NIB_PER_WORD - 1);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_DW-1:0]    r_shift;
    logic [c_DW-1:0]    w_shift_nxt;
    logic [c_DW-1:0]    w_merged;

    logic               r_valid;
    logic [c_DW-1:0]    r_data;
    logic [CW-1:0]      r_ncnt;
    logic               r_last;
    logic               r_err;
    logic [7:0]         r_err_cnt;

    logic               w_slot_free;
    logic               w_rden;
    logic               w_is_data;
    logic               w_is_sof;
    logic               w_is_eof;
    logic               w_load;
    logic [c_DW-1:0]    w_load_data;
    logic [CW-1:0]      w_load_ncnt;
    logic               w_load_last;
    logic               w_err;

    // Popping only when the output register can take a load removes any need
    // for a second holding stage.
    assign w_slot_free = !r_valid || O_READY;
    assign w_rden      = !EMPTY && w_slot_free && !RST;
    assign RDEN        = w_rden;

    assign w_is_data = !RDATA[4];
    assign w_is_sof  = RDATA[4] && (RDATA[3:0] == 4'h1);
    assign w_is_eof  = RDATA[4] && (RDATA[3:0] == 4'h2);

    always_comb begin
        w_merged = r_shift;
        for (int k = 0; k < NIB_PER_WORD; k++) begin
            if (r_cnt == c_CNT_W'(k)) begin
                w_merged[4*k +: 4] = RDATA[3:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_load_data = '0;
        w_load_ncnt = '0;
        w_load_last = 1'b0;
        w_err       = 1'b0;
        if (w_rden) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_is_sof) begin
                        w_state_nxt = ST_FILL;
                        w_cnt_nxt   = '0;
                        w_shift_nxt = '0;
                    end
                end
                ST_FILL: begin
                    if (w_is_data) begin
                        if (r_cnt == c_CNT_LAST) begin
                            w_load      = 1'b1;
                            w_load_data = w_merged;
                            w_load_ncnt = CW'(NIB_PER_WORD);
                            w_cnt_nxt   = '0;
                            w_shift_nxt = '0;
                        end else begin
                            w_shift_nxt = w_merged;
                            w_cnt_nxt   = r_cnt + 1'b1;
                        end
                    end else if (w_is_eof) begin
                        // Untouched upper nibbles are already zero, giving the padding.
                        w_load      = 1'b1;
                        w_load_data = r_shift;
                        w_load_ncnt = CW'(r_cnt);
                        w_load_last = 1'b1;
                        w_state_nxt = ST_HUNT;
                        w_cnt_nxt   = '0;
                        w_shift_nxt = '0;
                    end else if (w_is_sof) begin
                        w_err       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_shift_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_HUNT;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_ncnt    <= '0;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_load_data;
                r_ncnt  <= w_load_ncnt;
                r_last  <= w_load_last;
            end else if (O_READY) begin
                r_valid <= 1'b0;
            end
            r_err <= w_err;
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign O_VALID = r_valid;
    assign O_DATA  = r_data;
    assign O_NCNT  = r_ncnt;
    assign O_LAST  = r_last;
    assign O_ERR   = r_err;
    assign ERR_CNT = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_c2c_sym_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_c2c_sym_packer
// Description : Scoreboard bench for c2c_sym_packer with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c2c_sym_packer;

    localparam int NPW = 8;
    localparam int CWB = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             RDEN;
    logic [4:0]       RDATA = '0;
    logic             EMPTY = 1'b1;
    logic             O_VALID;
    logic             O_READY = 1'b0;
    logic [4*NPW-1:0] O_DATA;
    logic [CWB-1:0]   O_NCNT;
    logic             O_LAST;
    logic             O_ERR;
    logic [7:0]       ERR_CNT;

    c2c_sym_packer #(.NIB_PER_WORD(NPW), .CW(CWB)) dut (
        .CLK(CLK), .RST(RST), .RDEN(RDEN), .RDATA(RDATA), .EMPTY(EMPTY),
        .O_VALID(O_VALID), .O_READY(O_READY), .O_DATA(O_DATA), .O_NCNT(O_NCNT),
        .O_LAST(O_LAST), .O_ERR(O_ERR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4*NPW-1:0] data;
        int               ncnt;
        bit               last;
    } exp_t;

    logic [4:0] sym_q[$];
    exp_t       exp_q[$];
    int         n_total = 0;
    int         n_pass  = 0;
    int         err_seen = 0;
    int         empty_pct = 0;
    int         rdy_pct = 100;
    bit         rdy_force0 = 1'b0;

    // Frame-level reference: nibbles collected in a list, words cut on size or EOF.
    bit         m_in_frame = 1'b0;
    logic [3:0] m_nibs[$];
    int         m_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic m_emit(input bit last);
        exp_t e;
        e.data = '0;
        foreach (m_nibs[k]) e.data = e.data | ((4*NPW)'(m_nibs[k]) << (4*k));
        e.ncnt = m_nibs.size();
        e.last = last;
        exp_q.push_back(e);
        m_nibs.delete();
    endtask

    task automatic push_sym(input logic [4:0] s);
        sym_q.push_back(s);
        if (!s[4]) begin
            if (m_in_frame) begin
                m_nibs.push_back(s[3:0]);
                if (m_nibs.size() == NPW) m_emit(1'b0);
            end
        end else if (s[3:0] == 4'h1) begin
            if (m_in_frame) m_err++;
            m_in_frame = 1'b1;
            m_nibs.delete();
        end else if (s[3:0] == 4'h2) begin
            if (m_in_frame) m_emit(1'b1);
            m_in_frame = 1'b0;
        end
    endtask

    task automatic push_data(input logic [3:0] n);
        push_sym({1'b0, n});
    endtask

    task automatic drain();
        int n = 0;
        while ((sym_q.size() != 0 || exp_q.size() != 0 || O_VALID) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 5000) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d symbols/%0d words pending, required 0", sym_q.size(), exp_q.size());
        end
        repeat (3) @(negedge CLK);
    endtask

    // FIFO and sink model: pop on RDEN, then present new head and ready after the edge.
    initial begin
        bit popped;
        forever begin
            @(posedge CLK);
            popped = RDEN;
            #1;
            if (popped && sym_q.size() > 0) void'(sym_q.pop_front());
            EMPTY   = (sym_q.size() == 0) || ($urandom_range(0, 99) < empty_pct);
            RDATA   = EMPTY ? 5'($urandom) : sym_q[0];
            O_READY = rdy_force0 ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        end
    end

    bit               prev_hold = 1'b0;
    logic [4*NPW-1:0] hold_data;
    logic [CWB-1:0]   hold_ncnt;
    logic             hold_last;

    always @(negedge CLK) begin
        if (RST) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 64'(O_VALID), 64'd1);
                chk("hold_data", 64'(O_DATA), 64'(hold_data));
                chk("hold_ncnt_last", {O_NCNT, O_LAST}, {hold_ncnt, hold_last});
            end
            if (O_VALID && !O_READY) chk("rden_while_blocked", 64'(RDEN), 64'd0);
            if (EMPTY) chk("rden_while_empty", 64'(RDEN), 64'd0);
            if (O_ERR) err_seen++;
            if (O_VALID && O_READY) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_word: got data 0x%0h ncnt %0d, required no word", O_DATA, O_NCNT);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_data", 64'(O_DATA), 64'(e.data));
                    chk("word_ncnt", 64'(O_NCNT), 64'(e.ncnt));
                    chk("word_last", 64'(O_LAST), 64'(e.last));
                end
            end
            prev_hold = O_VALID && !O_READY;
            hold_data = O_DATA;
            hold_ncnt = O_NCNT;
            hold_last = O_LAST;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(O_VALID), 64'd0);
        chk({tag, "_data"}, 64'(O_DATA), 64'd0);
        chk({tag, "_ncnt_last_err"}, {O_NCNT, O_LAST, O_ERR}, 64'd0);
        chk({tag, "_err_cnt"}, 64'(ERR_CNT), 64'd0);
        chk({tag, "_rden"}, 64'(RDEN), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge CLK);
        check_reset_outputs("por");
        RST = 1'b0;

        // Mid-frame reset with a held word and a recorded error.
        rdy_force0 = 1'b1;
        push_sym(5'h11); push_data(4'h1); push_sym(5'h11);
        for (int i = 1; i <= 8; i++) push_data(4'(i));
        push_data(4'hC); push_data(4'hD);
        n = 0;
        while (!O_VALID && n < 200) begin @(negedge CLK); n++; end
        if (n >= 200) begin
            n_total++;
            $display("FAIL t1_wait_valid: got O_VALID=0, required 1");
        end
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        #1 check_reset_outputs("midframe_rst");
        sym_q.delete(); exp_q.delete(); m_nibs.delete();
        m_in_frame = 1'b0; m_err = 0; err_seen = 0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        rdy_force0 = 1'b0;

        // Pre-SOF data, EOF and filler are dropped in HUNT.
        push_data(4'h5); push_sym(5'h1F); push_sym(5'h12); push_sym(5'h10);
        // Full word followed by an empty EOF word.
        push_sym(5'h11);
        for (int i = 1; i <= 8; i++) push_data(4'(i));
        push_sym(5'h12);
        // Partial word.
        push_sym(5'h11); push_data(4'hA); push_data(4'hB); push_sym(5'h12);
        drain();
        chk("no_err_yet", 64'(err_seen), 64'd0);

        // Framing error in the middle of a frame.
        push_sym(5'h11); push_data(4'h1); push_data(4'h2);
        push_sym(5'h11); push_data(4'h3); push_sym(5'h12);
        drain();
        chk("err_pulses_t5", 64'(err_seen), 64'(m_err));
        chk("err_cnt_t5", 64'(ERR_CNT), 64'd1);

        // Backpressure with a backlog of symbols.
        empty_pct = 0;
        rdy_force0 = 1'b1;
        push_sym(5'h11);
        for (int i = 0; i < 19; i++) push_data(4'($urandom));
        n = 0;
        while (!O_VALID && n < 200) begin @(negedge CLK); n++; end
        repeat (5) @(negedge CLK);
        chk("bp_backlog_kept", 64'(sym_q.size() > 0), 64'd1);
        rdy_force0 = 1'b0;
        push_sym(5'h12);
        drain();

        // Random symbol mix with random stalls and backpressure.
        empty_pct = 30;
        rdy_pct = 70;
        for (int i = 0; i < 600; i++) begin
            int r;
            int f;
            r = $urandom_range(0, 99);
            if (r < 72) push_data(4'($urandom));
            else if (r < 80) push_sym(5'h11);
            else if (r < 90) push_sym(5'h12);
            else begin
                f = $urandom_range(0, 13);
                push_sym({1'b1, (f == 0) ? 4'h0 : 4'(f + 2)});
            end
        end
        drain();
        chk("err_pulses_rand", 64'(err_seen), 64'(m_err));
        chk("err_cnt_rand", 64'(ERR_CNT), 64'((m_err > 255) ? 255 : m_err));

        // Drive the error counter past saturation.
        empty_pct = 10;
        for (int i = 0; i < 301; i++) push_sym(5'h11);
        push_data(4'h9); push_sym(5'h12);
        drain();
        chk("err_pulses_sat", 64'(err_seen), 64'(m_err));
        chk("err_cnt_sat", 64'(ERR_CNT), 64'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
